// File: rtl/vga_fill_master_pkg.sv
// Shared constants for the VGA fill engine and its bus writer.
//   X_OFF / Y_OFF / DATA_OFF : register offsets from the VGA peripheral base
//   Y_WE_BIT                 : bit of the Y register that arms a frame-buffer write
//   FRAME_W / FRAME_H        : visible frame dimensions in pixels
package vga_fill_master_pkg;

  localparam logic [7:0] X_OFF    = 8'd0;
  localparam logic [7:0] Y_OFF    = 8'd1;
  localparam logic [7:0] DATA_OFF = 8'd2;
  localparam int         Y_WE_BIT = 7;
  localparam int         FRAME_W  = 160;
  localparam int         FRAME_H  = 120;

endpackage

// File: rtl/vga_bus_writer.sv
// Registered single-cycle bus write issuer.
//   CLK, RESET : system clock, synchronous active-high reset
//   issue      : the walker wants to write addr/data this cycle
//   gnt        : bus grant; an issue without grant is dropped and the walker holds
//   addr, data : write target and payload for the current issue
//   fire       : issue accepted this cycle (issue & gnt); write appears next cycle
//   bus_addr   : registered address, 8'h00 whenever no write is on the bus
//   bus_we     : registered write strobe, high for exactly one cycle per write
//   bus_data   : driven with the payload only while bus_we is high, else 8'hZZ
module vga_bus_writer (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       issue,
  input  logic       gnt,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic       fire,
  output logic [7:0] bus_addr,
  output logic       bus_we,
  inout  wire  [7:0] bus_data
);

  logic [7:0] addr_q;
  logic [7:0] data_q;
  logic       we_q;

  // Grant is judged at issue time: a suppressed issue never reaches the bus,
  // and the walker stays in its state so the same write is retried.
  assign fire = issue & gnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      we_q   <= 1'b0;
      addr_q <= 8'h00;
      data_q <= 8'h00;
    end else begin
      we_q   <= fire;
      addr_q <= fire ? addr : 8'h00;
      data_q <= fire ? data : 8'h00;
    end
  end

  assign bus_addr = addr_q;
  assign bus_we   = we_q;
  assign bus_data = we_q ? data_q : 8'hzz;

endmodule

// File: rtl/vga_fill_master.sv
// Second bus master that draws a filled rectangle into the VGA frame buffer.
// One accepted command becomes a colour write followed, per pixel in
// row-major order, by X write, Y write with the frame-buffer enable bit set,
// Y write with it cleared, and one advance cycle.
//   CLK, RESET          : system clock, synchronous active-high reset
//   CMD_VALID/CMD_READY : command handshake; a command is taken on the cycle
//                         both are high, and CMD_READY is high only when idle
//   CMD_X0..CMD_Y1      : inclusive rectangle corners; X1/Y1 clamp to the frame
//   CMD_COLOUR          : pixel value written to every pixel of the rectangle
//   BUS_REQ/BUS_GNT     : arbiter request/grant
//   BUS_ADDR/DATA/WE    : registered single-cycle writes to the VGA registers
//   BUSY                : command in progress (any state other than idle)
//   DONE                : one-cycle completion pulse
//   ERR                 : pulses with DONE when the command was rejected
module vga_fill_master
  import vga_fill_master_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hB0,
  parameter logic [7:0] X_MAX     = 8'd159,
  parameter logic [6:0] Y_MAX     = 7'd119
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [7:0] CMD_X0,
  input  logic [6:0] CMD_Y0,
  input  logic [7:0] CMD_X1,
  input  logic [6:0] CMD_Y1,
  input  logic       CMD_COLOUR,
  output logic       BUS_REQ,
  input  logic       BUS_GNT,
  output logic [7:0] BUS_ADDR,
  inout  wire  [7:0] BUS_DATA,
  output logic       BUS_WE,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WR_DATA, S_WR_X, S_WR_YSET, S_WR_YCLR, S_ADV, S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] x0_q, x1_q, cur_x_q;
  logic [6:0] y1_q, cur_y_q;
  logic       colour_q;
  logic       err_q;
  logic       bus_req_q;

  logic [7:0] x1_clamped;
  logic [6:0] y1_clamped;
  logic       cmd_bad;
  logic       accept;
  logic       issue;
  logic       fire;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  assign x1_clamped = (CMD_X1 > X_MAX) ? X_MAX : CMD_X1;
  assign y1_clamped = (CMD_Y1 > Y_MAX) ? Y_MAX : CMD_Y1;
  assign cmd_bad    = (CMD_X0 > x1_clamped) || (CMD_Y0 > y1_clamped) ||
                      (CMD_X0 > X_MAX) || (CMD_Y0 > Y_MAX);
  assign accept     = CMD_VALID && (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    wr_addr = 8'h00;
    wr_data = 8'h00;
    unique case (state_q)
      S_IDLE:    if (accept) state_d = cmd_bad ? S_DONE : S_REQ;
      S_REQ:     if (BUS_GNT) state_d = S_WR_DATA;
      S_WR_DATA: begin
        issue   = 1'b1;
        wr_addr = BASE_ADDR + DATA_OFF;
        wr_data = {7'b0, colour_q};
        if (fire) state_d = S_WR_X;
      end
      S_WR_X: begin
        issue   = 1'b1;
        wr_addr = BASE_ADDR + X_OFF;
        wr_data = cur_x_q;
        if (fire) state_d = S_WR_YSET;
      end
      S_WR_YSET: begin
        issue             = 1'b1;
        wr_addr           = BASE_ADDR + Y_OFF;
        wr_data           = {1'b0, cur_y_q};
        wr_data[Y_WE_BIT] = 1'b1;
        if (fire) state_d = S_WR_YCLR;
      end
      S_WR_YCLR: begin
        issue   = 1'b1;
        wr_addr = BASE_ADDR + Y_OFF;
        wr_data = {1'b0, cur_y_q};
        if (fire) state_d = S_ADV;
      end
      S_ADV: begin
        if (cur_x_q < x1_q || cur_y_q < y1_q) state_d = S_WR_X;
        else                                  state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      bus_req_q <= 1'b0;
      err_q     <= 1'b0;
      x0_q      <= 8'd0;
      x1_q      <= 8'd0;
      y1_q      <= 7'd0;
      cur_x_q   <= 8'd0;
      cur_y_q   <= 7'd0;
      colour_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      // Request is held from REQ through the last advance, including any
      // cycles spent waiting for a lost grant to come back.
      bus_req_q <= (state_d != S_IDLE) && (state_d != S_DONE);
      if (accept) begin
        x0_q     <= CMD_X0;
        x1_q     <= x1_clamped;
        y1_q     <= y1_clamped;
        cur_x_q  <= CMD_X0;
        cur_y_q  <= CMD_Y0;
        colour_q <= CMD_COLOUR;
        err_q    <= cmd_bad;
      end else if (state_q == S_ADV) begin
        // Clamped bounds guarantee these never wrap.
        if (cur_x_q < x1_q) begin
          cur_x_q <= cur_x_q + 8'd1;
        end else if (cur_y_q < y1_q) begin
          cur_x_q <= x0_q;
          cur_y_q <= cur_y_q + 7'd1;
        end
      end
    end
  end

  vga_bus_writer u_writer (
    .CLK      (CLK),
    .RESET    (RESET),
    .issue    (issue),
    .gnt      (BUS_GNT),
    .addr     (wr_addr),
    .data     (wr_data),
    .fire     (fire),
    .bus_addr (BUS_ADDR),
    .bus_we   (BUS_WE),
    .bus_data (BUS_DATA)
  );

  assign BUS_REQ   = bus_req_q;
  assign CMD_READY = (state_q == S_IDLE);
  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = (state_q == S_DONE);
  assign ERR       = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_vga_fill_master.sv
// Bench for vga_fill_master: a VGA peripheral model decodes bus writes into a
// frame buffer, and a scoreboard queue holds the write sequence each command
// must produce.
module tb_vga_fill_master;

  localparam logic [7:0] B0 = 8'hB0;
  localparam logic [7:0] B1 = 8'hB1;
  localparam logic [7:0] B2 = 8'hB2;
  localparam int FB_N = 160 * 120;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_x0 = 8'd0;
  logic [6:0] cmd_y0 = 7'd0;
  logic [7:0] cmd_x1 = 8'd0;
  logic [6:0] cmd_y1 = 7'd0;
  logic       cmd_colour = 1'b0;
  logic       bus_req;
  logic       bus_gnt = 1'b1;
  logic [7:0] bus_addr;
  wire  [7:0] bus_data;
  logic       bus_we;
  logic       busy;
  logic       done;
  logic       err;

  vga_fill_master dut (
    .CLK        (clk),
    .RESET      (rst),
    .CMD_VALID  (cmd_valid),
    .CMD_READY  (cmd_ready),
    .CMD_X0     (cmd_x0),
    .CMD_Y0     (cmd_y0),
    .CMD_X1     (cmd_x1),
    .CMD_Y1     (cmd_y1),
    .CMD_COLOUR (cmd_colour),
    .BUS_REQ    (bus_req),
    .BUS_GNT    (bus_gnt),
    .BUS_ADDR   (bus_addr),
    .BUS_DATA   (bus_data),
    .BUS_WE     (bus_we),
    .BUSY       (busy),
    .DONE       (done),
    .ERR        (err)
  );

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_writes = 0;
  int          first_wr_cyc = -1;
  int          last_wr_cyc = -1;
  logic [15:0] exp_q[$];
  bit          fb [0:FB_N-1];
  bit          exp_fb [0:FB_N-1];
  logic [7:0]  x_reg = 8'd0;
  logic [7:0]  y_reg = 8'd0;
  logic [7:0]  d_reg = 8'd0;
  logic        gnt_at_edge = 1'b1;
  logic        model_reset = 1'b0;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    gnt_at_edge <= bus_gnt;
  end

  // Peripheral model + write monitor. Bus values are sampled mid-cycle.
  // The frame-buffer write happens on the cycle after Y bit7 becomes set.
  always @(negedge clk) begin
    logic [15:0] e;
    int idx;
    if (model_reset) begin
      x_reg = 8'd0; y_reg = 8'd0; d_reg = 8'd0;
    end else begin
      if (y_reg[7]) begin
        idx = int'(y_reg[6:0]) * 160 + int'(x_reg);
        if (idx < FB_N) fb[idx] = d_reg[0];
      end
      if (bus_we === 1'b1) begin
        n_writes++;
        last_wr_cyc = cyc;
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        case (bus_addr)
          B0: x_reg = bus_data;
          B1: y_reg = bus_data;
          B2: d_reg = bus_data;
          default: ;
        endcase
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL bus_write: unexpected write addr=%h data=%h", bus_addr, bus_data);
        end else begin
          e = exp_q.pop_front();
          if ({bus_addr, bus_data} !== e) begin
            n_err++;
            $display("FAIL bus_write: got %h<=%h expected %h<=%h", bus_addr, bus_data, e[15:8], e[7:0]);
          end
        end
      end
      if (gnt_at_edge === 1'b0) begin
        n_cmp++;
        if (bus_we !== 1'b0 || !(bus_data === 8'hzz || bus_data === 8'h00)) begin
          n_err++;
          $display("FAIL no_grant_release: we=%b data=%h expected we=0 data=zz", bus_we, bus_data);
        end
      end
    end
  end

  // ---------------- model ----------------
  task automatic push_expected(input logic [7:0] x0, input logic [6:0] y0,
                               input logic [7:0] x1, input logic [6:0] y1,
                               input logic c, output bit rejected);
    int cx1, cy1;
    cx1 = (x1 > 8'd159) ? 159 : int'(x1);
    cy1 = (y1 > 7'd119) ? 119 : int'(y1);
    rejected = (int'(x0) > cx1) || (int'(y0) > cy1) || (x0 > 8'd159) || (y0 > 7'd119);
    if (!rejected) begin
      exp_q.push_back({B2, 7'b0, c});
      for (int y = int'(y0); y <= cy1; y++) begin
        for (int x = int'(x0); x <= cx1; x++) begin
          exp_q.push_back({B0, 8'(x)});
          exp_q.push_back({B1, 1'b1, 7'(y)});
          exp_q.push_back({B1, 1'b0, 7'(y)});
          exp_fb[y * 160 + x] = c;
        end
      end
    end
  endtask

  function automatic int image_diffs();
    int d = 0;
    for (int i = 0; i < FB_N; i++) if (fb[i] !== exp_fb[i]) d++;
    return d;
  endfunction

  // ---------------- driver ----------------
  // Issues one command from a negedge and waits for DONE. tenure counts cycles
  // from the colour-write issue through the final advance.
  task automatic run_cmd(input logic [7:0] x0, input logic [6:0] y0,
                         input logic [7:0] x1, input logic [6:0] y1, input logic c,
                         output int tenure, output int n_wr, output int done_gap,
                         output logic saw_err, output logic timed_out);
    int w0;
    bit rej;
    push_expected(x0, y0, x1, y1, c, rej);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL cmd_ready_before_cmd: got %b expected 1", cmd_ready);
    end
    w0 = n_writes;
    first_wr_cyc = -1;
    cmd_x0 = x0; cmd_y0 = y0; cmd_x1 = x1; cmd_y1 = y1; cmd_colour = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    timed_out = 1'b1; saw_err = 1'b0; tenure = 0; done_gap = 0;
    for (int i = 0; i < 5000; i++) begin
      if (done === 1'b1) begin
        timed_out = 1'b0;
        saw_err   = err;
        tenure    = cyc - first_wr_cyc + 1;
        done_gap  = cyc - last_wr_cyc;
        break;
      end
      @(negedge clk);
    end
    n_wr = n_writes - w0;
    n_cmp++;
    if (timed_out) begin
      n_err++;
      $display("FAIL done_timeout: no DONE within 5000 cycles");
    end
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || bus_req !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 8'h00 ||
        busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: ready=%b req=%b we=%b addr=%h busy=%b done=%b err=%b expected 1 0 0 00 0 0 0",
               cmd_ready, bus_req, bus_we, bus_addr, busy, done, err);
    end
    n_cmp++;
    if (!(bus_data === 8'hzz || bus_data === 8'h00)) begin
      n_err++;
      $display("FAIL reset_bus_data: got %h expected zz", bus_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_pixel();
    int t, nw, gap; logic e, to;
    run_cmd(8'd5, 7'd3, 8'd5, 7'd3, 1'b1, t, nw, gap, e, to);
    n_cmp++;
    if (nw != 4 || t != 5) begin
      n_err++; $display("FAIL single_counts: writes=%0d tenure=%0d expected 4 and 5", nw, t);
    end
    n_cmp++;
    if (gap != 1 || e !== 1'b0) begin
      n_err++; $display("FAIL single_done: gap=%0d err=%b expected 1 and 0", gap, e);
    end
    n_cmp++;
    if (fb[3 * 160 + 5] !== 1'b1 || image_diffs() != 0) begin
      n_err++; $display("FAIL single_image: pixel=%b diffs=%0d expected 1 and 0", fb[3 * 160 + 5], image_diffs());
    end
  endtask

  task automatic test_rect_2x2();
    int t, nw, gap; logic e, to;
    run_cmd(8'd10, 7'd20, 8'd11, 7'd21, 1'b1, t, nw, gap, e, to);
    n_cmp++;
    if (t != 17 || nw != 13) begin
      n_err++; $display("FAIL rect_counts: tenure=%0d writes=%0d expected 17 and 13", t, nw);
    end
    n_cmp++;
    if (image_diffs() != 0 || fb[20 * 160 + 9] !== 1'b0 || fb[21 * 160 + 12] !== 1'b0) begin
      n_err++; $display("FAIL rect_image: diffs=%0d expected 0", image_diffs());
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL rect_drained: %0d left expected 0", exp_q.size());
    end
  endtask

  task automatic test_clamp();
    int t, nw, gap; logic e, to;
    run_cmd(8'd158, 7'd119, 8'd200, 7'd119, 1'b1, t, nw, gap, e, to);
    n_cmp++;
    if (nw != 7 || e !== 1'b0) begin
      n_err++; $display("FAIL clamp_counts: writes=%0d err=%b expected 7 and 0", nw, e);
    end
    n_cmp++;
    if (image_diffs() != 0 || fb[119 * 160 + 159] !== 1'b1) begin
      n_err++; $display("FAIL clamp_image: diffs=%0d expected 0", image_diffs());
    end
  endtask

  task automatic test_reject();
    int w0; bit rej; logic req_seen;
    push_expected(8'd9, 7'd0, 8'd8, 7'd0, 1'b1, rej);
    w0 = n_writes;
    cmd_x0 = 8'd9; cmd_y0 = 7'd0; cmd_x1 = 8'd8; cmd_y1 = 7'd0; cmd_colour = 1'b1;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    req_seen = bus_req;
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b1) begin
      n_err++; $display("FAIL reject_pulse: done=%b err=%b expected 1 1", done, err);
    end
    @(negedge clk);
    req_seen = req_seen | bus_req;
    n_cmp++;
    if (done !== 1'b0 || err !== 1'b0 || cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL reject_one_cycle: done=%b err=%b ready=%b expected 0 0 1", done, err, cmd_ready);
    end
    repeat (2) begin
      @(negedge clk);
      req_seen = req_seen | bus_req;
    end
    n_cmp++;
    if (req_seen !== 1'b0 || n_writes != w0 || !(bus_data === 8'hzz || bus_data === 8'h00)) begin
      n_err++; $display("FAIL reject_no_bus: req=%b writes=%0d data=%h expected 0 0 zz", req_seen, n_writes - w0, bus_data);
    end
  endtask

  task automatic test_grant_drop();
    int t, nw, gap; logic e, to; bit found;
    fork
      run_cmd(8'd40, 7'd50, 8'd41, 7'd50, 1'b1, t, nw, gap, e, to);
      begin
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (bus_we === 1'b1 && bus_addr === B0) begin found = 1'b1; break; end
        end
        if (found) begin
          bus_gnt = 1'b0;
          repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (bus_req !== 1'b1) begin
              n_err++; $display("FAIL drop_req_held: got %b expected 1", bus_req);
            end
          end
          bus_gnt = 1'b1;
        end
      end
    join
    n_cmp++;
    if (!found || nw != 7) begin
      n_err++; $display("FAIL drop_writes: found=%b writes=%0d expected 1 and 7", found, nw);
    end
    n_cmp++;
    if (image_diffs() != 0 || exp_q.size() != 0) begin
      n_err++; $display("FAIL drop_image: diffs=%0d left=%0d expected 0 0", image_diffs(), exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int t, nw, gap; logic e, to;
    logic [7:0] x0; logic [6:0] y0;
    run_cmd(8'd10, 7'd20, 8'd10, 7'd21, 1'b0, t, nw, gap, e, to);
    for (int k = 0; k < 4; k++) begin
      x0 = 8'($urandom_range(0, 30));
      y0 = 7'($urandom_range(0, 25));
      run_cmd(x0, y0, x0 + 8'($urandom_range(0, 3)), y0 + 7'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), t, nw, gap, e, to);
    end
    n_cmp++;
    if (image_diffs() != 0 || exp_q.size() != 0) begin
      n_err++; $display("FAIL b2b_image: diffs=%0d left=%0d expected 0 0", image_diffs(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid_fill();
    bit rej;
    push_expected(8'd60, 7'd60, 8'd63, 7'd63, 1'b1, rej);
    cmd_x0 = 8'd60; cmd_y0 = 7'd60; cmd_x1 = 8'd63; cmd_y1 = 7'd63; cmd_colour = 1'b1;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus_req !== 1'b0 || bus_we !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 ||
        !(bus_data === 8'hzz || bus_data === 8'h00)) begin
      n_err++;
      $display("FAIL mid_reset: req=%b we=%b busy=%b ready=%b data=%h expected 0 0 0 1 zz",
               bus_req, bus_we, busy, cmd_ready, bus_data);
    end
    rst = 1'b0;
    model_reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    model_reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_rect_2x2();
    test_clamp();
    test_reject();
    test_grant_drop();
    test_back_to_back();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
